// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage of the pipelined MIPS core.
// Holds the mult/div op codes, forwarding select codes, ALU op encodings,
// the mult/div FSM states and the default datapath/address widths.
package pipe_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    // Mult/div unit operations presented by ID/EX.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6,
        MD_MT    = 3'd7
    } md_op_e;

    // Operand source selects; code 3 falls back to the register file.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_RF3 = 2'd3
    } fwd_sel_e;

    // ALU operations. Bit 0 of aluc also picks HI (0) or LO (1) for mthi/mtlo.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluc_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the unit for DW iterations.
    function automatic logic mdIsIter(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start_i, op_i       launch an iterative op (mult/multu/div/divu)
//   opA_i, opB_i        operands, latched on start
//   mt_i, mtLo_i, mtData_i  direct write of HI (mtLo_i=0) or LO (mtLo_i=1)
//   hi_o, lo_o          architectural HI/LO
//   busy_o              iteration in progress
module pipe_muldiv
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  md_op_e        op_i,
    input  logic [DW-1:0] opA_i,
    input  logic [DW-1:0] opB_i,
    input  logic          mt_i,
    input  logic          mtLo_i,
    input  logic [DW-1:0] mtData_i,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          busy_o
);

    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] lsr_q, lsr_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          isDiv_q, isDiv_d;
    logic          negLo_q, negLo_d;
    logic          negHi_q, negHi_d;
    logic          divZero_q, divZero_d;

    logic          isSigned, aNeg, bNeg;
    logic [DW:0]   mulSum;
    logic [DW-1:0] mulAcc, mulLsr;
    logic [DW:0]   divSh;
    logic          divGe;
    logic [DW-1:0] divDiff, divAcc, divLsr;
    logic [2*DW-1:0] prod;
    logic [DW-1:0] quot, rem;

    assign busy_o = (state_q == MD_RUN);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // One iteration of both algorithms. Mult: shift-add with acc as the upper
    // half and lsr holding the multiplier being consumed from bit 0. Div:
    // restoring division, acc is the partial remainder and lsr shifts the
    // dividend out of the top while quotient bits enter at the bottom.
    always_comb begin
        mulSum  = {1'b0, acc_q} + (lsr_q[0] ? {1'b0, opb_q} : '0);
        mulAcc  = mulSum[DW:1];
        mulLsr  = {mulSum[0], lsr_q[DW-1:1]};
        divSh   = {acc_q, lsr_q[DW-1]};
        divGe   = (divSh >= {1'b0, opb_q});
        divDiff = divSh[DW-1:0] - opb_q;
        divAcc  = divGe ? divDiff : divSh[DW-1:0];
        divLsr  = {lsr_q[DW-2:0], divGe};
        // Sign fix-up for the final result; divisor zero forces an all-ones
        // quotient while the remainder naturally ends up equal to the dividend.
        prod    = negLo_q ? -{mulAcc, mulLsr} : {mulAcc, mulLsr};
        quot    = divZero_q ? '1 : (negLo_q ? -divLsr : divLsr);
        rem     = negHi_q ? -divAcc : divAcc;
    end

    // Next-state logic: launch latches operand magnitudes and sign flags,
    // RUN iterates and writes HI/LO on the last count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lsr_d     = lsr_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        isDiv_d   = isDiv_q;
        negLo_d   = negLo_q;
        negHi_d   = negHi_q;
        divZero_d = divZero_q;
        isSigned  = (op_i == MD_MULT) || (op_i == MD_DIV);
        aNeg      = isSigned & opA_i[DW-1];
        bNeg      = isSigned & opB_i[DW-1];

        case (state_q)
            MD_IDLE: begin
                if (mt_i) begin
                    if (mtLo_i) lo_d = mtData_i;
                    else        hi_d = mtData_i;
                end
                if (start_i) begin
                    state_d   = MD_RUN;
                    cnt_d     = '0;
                    acc_d     = '0;
                    lsr_d     = aNeg ? -opA_i : opA_i;
                    opb_d     = bNeg ? -opB_i : opB_i;
                    isDiv_d   = (op_i == MD_DIV) || (op_i == MD_DIVU);
                    negLo_d   = aNeg ^ bNeg;
                    negHi_d   = aNeg;
                    divZero_d = (opB_i == '0);
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = isDiv_q ? divAcc : mulAcc;
                lsr_d = isDiv_q ? divLsr : mulLsr;
                if (cnt_q == LAST) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                    hi_d    = isDiv_q ? rem  : prod[2*DW-1:DW];
                    lo_d    = isDiv_q ? quot : prod[DW-1:0];
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State registers; reset abandons any op in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            lsr_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            isDiv_q   <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            lsr_q     <= lsr_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            isDiv_q   <= isDiv_d;
            negLo_q   <= negLo_d;
            negHi_q   <= negHi_d;
            divZero_q <= divZero_d;
        end
    end

endmodule

// File: rtl/pipe_exe_md.sv
// Execute stage: operand forwarding muxes, ALU, mult/div unit and EX/MEM
// register. Back-pressures ID (ex_ready) while mult/div work is in flight.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_valid/ex_ready/flush    ID/EX handshake and kill
//   rd1, rd2, fwd_*            operand sources and forwarding selects
//   shamt, imm, pc8, shift, immc, aludc, aluc, ovf_trap   ALU controls
//   md_op, wa_d, we_d          mult/div op, destination register/write
//   em_*                       registered EX/MEM outputs and flags
//   md_busy                    mult/div iterating
module pipe_exe_md
    import pipe_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          ex_ready,
    input  logic          flush,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic [1:0]    fwd_a,
    input  logic [1:0]    fwd_b,
    input  logic [DW-1:0] fwd_mem,
    input  logic [DW-1:0] fwd_wb,
    input  logic [DW-1:0] shamt,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] pc8,
    input  logic          shift,
    input  logic          immc,
    input  logic          aludc,
    input  logic [3:0]    aluc,
    input  logic          ovf_trap,
    input  logic [2:0]    md_op,
    input  logic [AW-1:0] wa_d,
    input  logic          we_d,
    output logic          em_valid,
    output logic          em_we,
    output logic [DW-1:0] em_wd,
    output logic [AW-1:0] em_wa,
    output logic          em_zero,
    output logic          em_carry,
    output logic          em_negative,
    output logic          em_overflow,
    output logic          em_ovf_exc,
    output logic          md_busy
);

    localparam int SW = $clog2(DW);

    md_op_e        mdOp;
    logic [DW-1:0] opA, opB, bSel, aluRes;
    logic [DW:0]   addSum;
    logic          isSub, aluCarry, aluOvf;
    logic          accept, mdStart, mtWrite, ovfExc;
    logic [DW-1:0] mdHi, mdLo;

    logic          emValid_q, emValid_d;
    logic          emWe_q, emWe_d;
    logic [DW-1:0] emWd_q, emWd_d;
    logic [AW-1:0] emWa_q, emWa_d;
    logic [3:0]    emFlags_q, emFlags_d;
    logic          emExc_q, emExc_d;

    assign mdOp     = md_op_e'(md_op);
    assign ex_ready = !(md_busy && (mdOp != MD_NONE));
    assign accept   = id_valid && ex_ready && !flush;
    assign mdStart  = accept && mdIsIter(mdOp);
    assign mtWrite  = accept && (mdOp == MD_MT);
    assign ovfExc   = ovf_trap && aluOvf;

    // Operand selection: forwarding first, then shamt/imm overrides.
    always_comb begin
        case (fwd_sel_e'(fwd_a))
            FWD_MEM: opA = fwd_mem;
            FWD_WB:  opA = fwd_wb;
            default: opA = rd1;
        endcase
        case (fwd_sel_e'(fwd_b))
            FWD_MEM: opB = fwd_mem;
            FWD_WB:  opB = fwd_wb;
            default: opB = rd2;
        endcase
        if (shift) opA = shamt;
        if (immc)  opB = imm;
    end

    // ALU. Subtract is a + ~b + 1, so carry is the no-borrow carry-out.
    // Carry and overflow are only meaningful for add/sub and read 0 otherwise.
    always_comb begin
        isSub    = (aluc_e'(aluc) == ALU_SUB);
        bSel     = isSub ? ~opB : opB;
        addSum   = {1'b0, opA} + {1'b0, bSel} + {{DW{1'b0}}, isSub};
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        case (aluc_e'(aluc))
            ALU_ADD, ALU_SUB: begin
                aluRes   = addSum[DW-1:0];
                aluCarry = addSum[DW];
                aluOvf   = (opA[DW-1] == bSel[DW-1]) && (addSum[DW-1] != opA[DW-1]);
            end
            ALU_AND:  aluRes = opA & opB;
            ALU_OR:   aluRes = opA | opB;
            ALU_XOR:  aluRes = opA ^ opB;
            ALU_NOR:  aluRes = ~(opA | opB);
            ALU_SLT:  aluRes = {{(DW-1){1'b0}}, ($signed(opA) < $signed(opB))};
            ALU_SLTU: aluRes = {{(DW-1){1'b0}}, (opA < opB)};
            ALU_SLL:  aluRes = opB << opA[SW-1:0];
            ALU_SRL:  aluRes = opB >> opA[SW-1:0];
            ALU_SRA:  aluRes = $signed(opB) >>> opA[SW-1:0];
            ALU_LUI:  aluRes = {opB[DW/2-1:0], {(DW/2){1'b0}}};
            default:  aluRes = '0;
        endcase
    end

    pipe_muldiv #(.DW(DW)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mdStart),
        .op_i     (mdOp),
        .opA_i    (opA),
        .opB_i    (opB),
        .mt_i     (mtWrite),
        .mtLo_i   (aluc[0]),
        .mtData_i (opA),
        .hi_o     (mdHi),
        .lo_o     (mdLo),
        .busy_o   (md_busy)
    );

    // EX/MEM next state. A bubble clears valid/we/exc but holds data and flags.
    // Mult/div launches and mthi/mtlo never write the register file.
    always_comb begin
        emValid_d = 1'b0;
        emWe_d    = 1'b0;
        emExc_d   = 1'b0;
        emWd_d    = emWd_q;
        emWa_d    = emWa_q;
        emFlags_d = emFlags_q;
        if (accept) begin
            emValid_d = 1'b1;
            emExc_d   = ovfExc;
            emWe_d    = we_d && !ovfExc && !mdIsIter(mdOp) && (mdOp != MD_MT);
            emWa_d    = aludc ? AW'(LINK_REG) : wa_d;
            emFlags_d = {(aluRes == '0), aluCarry, aluRes[DW-1], aluOvf};
            if (aludc)                 emWd_d = pc8;
            else if (mdOp == MD_MFHI)  emWd_d = mdHi;
            else if (mdOp == MD_MFLO)  emWd_d = mdLo;
            else                       emWd_d = aluRes;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            emValid_q <= 1'b0;
            emWe_q    <= 1'b0;
            emWd_q    <= '0;
            emWa_q    <= '0;
            emFlags_q <= '0;
            emExc_q   <= 1'b0;
        end else begin
            emValid_q <= emValid_d;
            emWe_q    <= emWe_d;
            emWd_q    <= emWd_d;
            emWa_q    <= emWa_d;
            emFlags_q <= emFlags_d;
            emExc_q   <= emExc_d;
        end
    end

    assign em_valid    = emValid_q;
    assign em_we       = emWe_q;
    assign em_wd       = emWd_q;
    assign em_wa       = emWa_q;
    assign em_zero     = emFlags_q[3];
    assign em_carry    = emFlags_q[2];
    assign em_negative = emFlags_q[1];
    assign em_overflow = emFlags_q[0];
    assign em_ovf_exc  = emExc_q;

endmodule

// File: tb/tb_pipe_exe_md.sv
// Scoreboard bench for pipe_exe_md: the driver pushes hand-computed EX/MEM
// results when an instruction is accepted; a monitor pops and compares
// whenever em_valid is seen.
module tb_pipe_exe_md;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, ex_ready, flush;
    logic [31:0] rd1, rd2, fwd_mem, fwd_wb, shamt, imm, pc8;
    logic [1:0]  fwd_a, fwd_b;
    logic        shift, immc, aludc, ovf_trap, we_d;
    logic [3:0]  aluc;
    logic [2:0]  md_op;
    logic [4:0]  wa_d;
    logic        em_valid, em_we, em_zero, em_carry, em_negative, em_overflow, em_ovf_exc, md_busy;
    logic [31:0] em_wd;
    logic [4:0]  em_wa;

    typedef struct {
        logic [31:0] wd;
        logic [4:0]  wa;
        logic        we;
        logic        exc;
        logic        chkF;
        logic [3:0]  flags;   // {zero, carry, negative, overflow}
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    int   total = 0;
    int   bad   = 0;
    int   stalls;

    pipe_exe_md #(.DW(32), .AW(5), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .ex_ready(ex_ready), .flush(flush),
        .rd1(rd1), .rd2(rd2), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
        .shamt(shamt), .imm(imm), .pc8(pc8), .shift(shift), .immc(immc), .aludc(aludc),
        .aluc(aluc), .ovf_trap(ovf_trap), .md_op(md_op), .wa_d(wa_d), .we_d(we_d),
        .em_valid(em_valid), .em_we(em_we), .em_wd(em_wd), .em_wa(em_wa),
        .em_zero(em_zero), .em_carry(em_carry), .em_negative(em_negative),
        .em_overflow(em_overflow), .em_ovf_exc(em_ovf_exc), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] wd, input logic [4:0] wa, input logic we,
                                input logic exc, input logic chkF, input logic [3:0] flags);
        exp_t e;
        e.wd = wd; e.wa = wa; e.we = we; e.exc = exc; e.chkF = chkF; e.flags = flags;
        return e;
    endfunction

    task automatic clearVec();
        rd1 = 0; rd2 = 0; fwd_a = 0; fwd_b = 0; fwd_mem = 0; fwd_wb = 0;
        shamt = 0; imm = 0; pc8 = 0; shift = 0; immc = 0; aludc = 0;
        aluc = ALU_ADD; ovf_trap = 0; md_op = MD_NONE; wa_d = 0; we_d = 0; flush = 0;
    endtask

    // Present the current vector, wait out any stall (bounded), record the
    // expectation on the accept edge and return at the following negedge.
    task automatic applyStimulus(input exp_t e, output int nStall);
        nStall = 0;
        id_valid = 1'b1;
        #1;
        while (!ex_ready && nStall < 200) begin
            @(negedge clk);
            #1;
            nStall++;
        end
        if (!ex_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL stall_bound: got ex_ready=0 expected 1 within 200 cycles");
        end else if (!flush) begin
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        id_valid = 1'b0;
        clearVec();
    endtask

    // Monitor: every valid EX/MEM entry must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && em_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_output: got em_wd=%h expected no output", em_wd);
            end else begin
                mon = sb.pop_front();
                checkOutput("em_wd", em_wd, mon.wd);
                checkOutput("em_wa", {27'd0, em_wa}, {27'd0, mon.wa});
                checkOutput("em_we", {31'd0, em_we}, {31'd0, mon.we});
                checkOutput("em_ovf_exc", {31'd0, em_ovf_exc}, {31'd0, mon.exc});
                if (mon.chkF)
                    checkOutput("em_flags", {28'd0, em_zero, em_carry, em_negative, em_overflow},
                                {28'd0, mon.flags});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0;
        clearVec();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_em_valid", {31'd0, em_valid}, 32'd0);
        checkOutput("reset_em_wd", em_wd, 32'd0);
        checkOutput("reset_em_we_exc", {30'd0, em_we, em_ovf_exc}, 32'd0);
        checkOutput("reset_flags", {28'd0, em_zero, em_carry, em_negative, em_overflow}, 32'd0);
        checkOutput("reset_md_busy", {31'd0, md_busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Forward A from MEM: 0x10 + 2
        rd1 = 1; fwd_mem = 32'h10; fwd_a = 1; rd2 = 2; wa_d = 5; we_d = 1;
        applyStimulus(mk(32'h12, 5, 1, 0, 1, 4'b0000), stalls);
        // Forward B from WB, subtract: 0x20 - 0x100
        rd1 = 32'h20; rd2 = 32'h999; fwd_b = 2; fwd_wb = 32'h100; aluc = ALU_SUB; wa_d = 6; we_d = 1;
        applyStimulus(mk(32'hFFFFFF20, 6, 1, 0, 1, 4'b0010), stalls);
        // Signed overflow with trap
        rd1 = 32'h7FFFFFFF; immc = 1; imm = 1; ovf_trap = 1; wa_d = 7; we_d = 1;
        applyStimulus(mk(32'h80000000, 7, 0, 1, 1, 4'b0011), stalls);
        // Same overflow without trap keeps the write
        rd1 = 32'h7FFFFFFF; immc = 1; imm = 1; wa_d = 7; we_d = 1;
        applyStimulus(mk(32'h80000000, 7, 1, 0, 1, 4'b0011), stalls);
        // Shift by shamt: 1 << 4
        shift = 1; shamt = 4; rd2 = 1; fwd_b = 3; aluc = ALU_SLL; wa_d = 9; we_d = 1;
        applyStimulus(mk(32'h10, 9, 1, 0, 1, 4'b0000), stalls);
        // Link: result pc8 to register 31
        aludc = 1; pc8 = 32'h00400008; wa_d = 3; we_d = 1;
        applyStimulus(mk(32'h00400008, 31, 1, 0, 1, 4'b1000), stalls);
        // Zero result: 5 - 5
        rd1 = 5; rd2 = 5; aluc = ALU_SUB; wa_d = 10; we_d = 1;
        applyStimulus(mk(32'h0, 10, 1, 0, 1, 4'b1100), stalls);

        // Flush: bubble, data holds previous value
        rd1 = 1; rd2 = 1; wa_d = 11; we_d = 1; flush = 1;
        applyStimulus(mk(32'h2, 11, 1, 0, 0, 4'b0000), stalls);
        checkOutput("flush_valid", {31'd0, em_valid}, 32'd0);
        checkOutput("flush_we", {31'd0, em_we}, 32'd0);
        checkOutput("flush_wd_hold", em_wd, 32'h0);

        // Signed mult -2 * 3, then mfhi/mflo
        md_op = MD_MULT; rd1 = 32'hFFFFFFFE; rd2 = 3; wa_d = 11; we_d = 1;
        applyStimulus(mk(32'h1, 11, 0, 0, 1, 4'b0100), stalls);
        md_op = MD_MFHI; wa_d = 12; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFF, 12, 1, 0, 0, 4'b0000), stalls);
        checkOutput("mult_stalls", stalls, 32);
        md_op = MD_MFLO; wa_d = 13; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFA, 13, 1, 0, 0, 4'b0000), stalls);
        checkOutput("mflo_nostall", stalls, 0);

        // Signed div -7 / 2 with an ALU op proceeding during iteration
        md_op = MD_DIV; rd1 = 32'hFFFFFFF9; rd2 = 2; wa_d = 14; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFB, 14, 0, 0, 1, 4'b0010), stalls);
        rd1 = 1; rd2 = 1; wa_d = 15; we_d = 1;
        applyStimulus(mk(32'h2, 15, 1, 0, 1, 4'b0000), stalls);
        checkOutput("alu_during_busy", stalls, 0);
        md_op = MD_MFLO; wa_d = 16; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFD, 16, 1, 0, 0, 4'b0000), stalls);
        checkOutput("div_stalls", stalls, 31);
        md_op = MD_MFHI; wa_d = 17; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFF, 17, 1, 0, 0, 4'b0000), stalls);

        // divu 5 / 0
        md_op = MD_DIVU; rd1 = 5; rd2 = 0; wa_d = 18; we_d = 1;
        applyStimulus(mk(32'h5, 18, 0, 0, 1, 4'b0000), stalls);
        md_op = MD_MFLO; wa_d = 19; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFF, 19, 1, 0, 0, 4'b0000), stalls);
        checkOutput("divz_stalls", stalls, 32);
        md_op = MD_MFHI; wa_d = 20; we_d = 1;
        applyStimulus(mk(32'h5, 20, 1, 0, 0, 4'b0000), stalls);

        // multu max * max = 0xFFFFFFFE_00000001
        md_op = MD_MULTU; rd1 = 32'hFFFFFFFF; rd2 = 32'hFFFFFFFF; wa_d = 21; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFE, 21, 0, 0, 0, 4'b0000), stalls);
        md_op = MD_MFHI; wa_d = 22; we_d = 1;
        applyStimulus(mk(32'hFFFFFFFE, 22, 1, 0, 0, 4'b0000), stalls);
        md_op = MD_MFLO; wa_d = 23; we_d = 1;
        applyStimulus(mk(32'h1, 23, 1, 0, 0, 4'b0000), stalls);

        // mthi / mtlo (aluc[0] picks LO)
        md_op = MD_MT; aluc = ALU_ADD; rd1 = 32'h1234; wa_d = 24; we_d = 1;
        applyStimulus(mk(32'h1234, 24, 0, 0, 0, 4'b0000), stalls);
        md_op = MD_MFHI; wa_d = 25; we_d = 1;
        applyStimulus(mk(32'h1234, 25, 1, 0, 0, 4'b0000), stalls);
        md_op = MD_MT; aluc = ALU_SUB; rd1 = 32'hABCD; wa_d = 26; we_d = 1;
        applyStimulus(mk(32'hABCD, 26, 0, 0, 0, 4'b0000), stalls);
        md_op = MD_MFLO; wa_d = 27; we_d = 1;
        applyStimulus(mk(32'hABCD, 27, 1, 0, 0, 4'b0000), stalls);

        // Reset during iteration 10 of a mult abandons it and clears HI/LO
        md_op = MD_MULT; rd1 = 3; rd2 = 5; wa_d = 28; we_d = 1;
        applyStimulus(mk(32'h8, 28, 0, 0, 0, 4'b0000), stalls);
        repeat (9) @(negedge clk);
        checkOutput("busy_before_reset", {31'd0, md_busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_busy", {31'd0, md_busy}, 32'd0);
        checkOutput("reset_mid_valid", {31'd0, em_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        md_op = MD_MFHI; wa_d = 29; we_d = 1;
        applyStimulus(mk(32'h0, 29, 1, 0, 0, 4'b0000), stalls);
        md_op = MD_MFLO; wa_d = 30; we_d = 1;
        applyStimulus(mk(32'h0, 30, 1, 0, 0, 4'b0000), stalls);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_exe_md.md
# pipe_exe_md

Parametrised execute stage for the pipelined MIPS core. It adds operand forwarding, a registered EX/MEM output with valid/we, a trapping overflow mode, and an iterative multiply/divide unit with HI/LO registers. It sits between the ID/EX register and the memory stage, and back-pressures ID while mult/div work is in flight.

## Interface
- DW, 32, datapath width
- AW, 5, register-address width
- LINK_REG, 31, write address for jal/jalr (aludc=1)
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- id_valid  in  1  instruction presented by ID/EX
- ex_ready  out  1  stage accepts the presented instruction this cycle
- flush  in  1  discard the presented instruction
- rd1, rd2  in  DW  register-file operands
- fwd_a, fwd_b  in  2  operand source select: 0 regfile, 1 fwd_mem, 2 fwd_wb, 3 regfile
- fwd_mem, fwd_wb  in  DW  forwarded results
- shamt, imm, pc8  in  DW  extended shift amount, immediate, PC+8
- shift, immc, aludc  in  1  ALU-A = shamt; ALU-B = imm; result = pc8 with address LINK_REG
- aluc  in  4  ALU operation, encoding as the existing alu
- ovf_trap  in  1  signed overflow suppresses the write
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi/mtlo (selected by aluc[0]: 0 hi, 1 lo)
- wa_d  in  AW  destination register
- we_d  in  1  destination write enable
- em_valid, em_we  out  1  EX/MEM valid and register write
- em_wd  out  DW  EX/MEM result
- em_wa  out  AW  EX/MEM write address
- em_zero, em_carry, em_negative, em_overflow  out  1  registered ALU flags
- em_ovf_exc  out  1  overflow trap taken
- md_busy  out  1  mult/div iterating

## Operation
- Operand A = fwd_a mux, or shamt when shift=1. Operand B = fwd_b mux, or imm when immc=1. Both feed the alu.
- Accept condition: id_valid & ex_ready & !flush.
- On accept, the EX/MEM register loads:
  - em_valid=1
  - em_wd = alu result, pc8, HI or LO
  - em_wa = wa_d, or LINK_REG when aludc=1
  - em_we = we_d, forced to 0 when ovf_trap & overflow
  - em_ovf_exc = ovf_trap & overflow
  - all four flags
- Without accept, EX/MEM loads a bubble: em_valid=0, em_we=0, em_ovf_exc=0. em_wd and the flags hold their values.
- ex_ready = !(md_busy & md_op≠0). A non-MD op proceeds while the unit iterates.
- mult/multu/div/divu: operands are latched, md_busy rises, and the op runs for DW iterations. em_we is forced to 0.
- mult/multu: radix-2 shift-add. The signed form runs on magnitudes and negates the 2·DW product at the end. {HI,LO} = product.
- div/divu: restoring division. The signed quotient truncates toward zero and the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend. Still DW cycles.
- mthi/mtlo: write operand A into HI/LO on the accept edge. em_we=0.
- mfhi/mflo: read the HI/LO register value.
- flush affects only the presented instruction. An in-flight mult/div always completes.
- Reset: all em_* outputs = 0, HI = LO = 0, md_busy = 0, iteration counter = 0. A reset mid-iteration abandons the op, leaving HI = LO = 0.

## Timing
- Non-MD result: visible on em_* one clock after the accept edge.
- MD op accepted at edge T: md_busy=1 from T to T+DW.
  - HI/LO update at edge T+DW, where md_busy falls.
  - ex_ready for a dependent MD op is 1 in the cycle after T+DW.
  - mfhi accepted that cycle sees the new value.
- Back-to-back MD ops: the second is accepted the cycle after busy falls.
- There is no bypass of HI/LO from the final iteration.
- mthi/mtlo while busy stalls like any MD op.
- Simultaneous flush and stall: the bubble is loaded and flush has priority.

## Structure
- Shared package `pipe_pkg` holds:
  - md_op codes, MD_NONE..MD_MT
  - fwd select codes
  - aluc encodings
  - DW/AW defaults
- One sub-module, `pipe_muldiv`: a two-state FSM (IDLE, RUN) with a $clog2(DW)+1 counter, HI/LO ownership and sign fix-up. The top level holds the muxes, the alu instance and the EX/MEM register.

## Test plan
- Forwarding: rd1=1, fwd_mem=0x10, fwd_a=1, aluc=add, rd2=2 → next cycle em_wd=0x12, em_valid=1.
- Overflow trap: A=0x7FFFFFFF, B=1, add, ovf_trap=1 → em_overflow=1, em_ovf_exc=1, em_we=0.
- mult: 0xFFFFFFFE × 3 signed, then mfhi/mflo presented immediately.
  - Expect ex_ready=0 for 32 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- div: −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu by 0 with dividend 5 → LO=0xFFFFFFFF, HI=5.
- Reset and flush:
  - rst_n low at iteration 10 → md_busy=0, HI=LO=0, em_valid=0 next edge.
  - flush with id_valid=1 → bubble.
